// File: rtl/psk_phase_acq.sv
// PSK phase acquisition: sweeps the NCO phase word in fixed steps, correlates the sample stream
// against i_code per step and keeps the strongest step. Optional macro: PSK_ACQ_ABS_METRIC_EN.
module psk_phase_acq #(
    parameter int PHASE_W    = 13,
    parameter int PHASE_STEP = 512,
    parameter int DWELL      = 1024,
    parameter int SETTLE_CYC = 4,
    parameter int ACC_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sample_en,
    input  logic               sample_in,
    input  logic               i_code,
    output logic [PHASE_W-1:0] phase_word,
    output logic               busy,
    output logic               done,
    output logic               corr_valid,
    output logic [ACC_W-1:0]   corr_value,
    output logic [PHASE_W-1:0] best_phase,
    output logic [ACC_W-1:0]   best_mag
`ifdef PSK_ACQ_ABS_METRIC_EN
    ,
    output logic               best_inv
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int DWC_W = $clog2(DWELL + 1);

    localparam logic [SET_W-1:0]         SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [DWC_W-1:0]         DWELL_LAST  = DWC_W'(DWELL - 1);
    localparam logic [PHASE_W-1:0]       STEP_INC    = PHASE_W'(PHASE_STEP);
    localparam logic [PHASE_W-1:0]       LAST_PHASE  = PHASE_W'((2 ** PHASE_W) - PHASE_STEP);
    localparam logic signed [ACC_W-1:0]  ACC_MAX     = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN     = -ACC_MAX;
    localparam logic signed [ACC_W-1:0]  ONE         = ACC_W'(1);

    state_t                    state;
    logic [SET_W-1:0]          settle_cnt;
    logic [DWC_W-1:0]          dwell_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_inc;
    logic signed [ACC_W-1:0]   metric;

    // Saturating +/-1 update for the strobe being integrated this cycle.
    always_comb begin
        acc_inc = acc;
        if (sample_in == i_code) begin
            if (acc != ACC_MAX) acc_inc = acc + ONE;
        end else begin
            if (acc != ACC_MIN) acc_inc = acc - ONE;
        end
    end

    always_comb begin
`ifdef PSK_ACQ_ABS_METRIC_EN
        metric = acc[ACC_W-1] ? -acc : acc;
`else
        metric = acc;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            acc        <= '0;
            phase_word <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            corr_valid <= 1'b0;
            corr_value <= '0;
            best_phase <= '0;
            best_mag   <= '0;
`ifdef PSK_ACQ_ABS_METRIC_EN
            best_inv   <= 1'b0;
`endif
        end else begin
            corr_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        phase_word <= '0;
                        acc        <= '0;
                        corr_value <= '0;
                        best_mag   <= '0;
                        best_phase <= '0;
`ifdef PSK_ACQ_ABS_METRIC_EN
                        best_inv   <= 1'b0;
`endif
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        acc       <= '0;
                        dwell_cnt <= '0;
                        state     <= ST_DWELL;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (sample_en) begin
                        acc       <= acc_inc;
                        dwell_cnt <= dwell_cnt + 1'b1;
                        if (dwell_cnt == DWELL_LAST) state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    corr_value <= acc;
                    corr_valid <= 1'b1;
                    // Strict compare: on a tie the earlier phase stays best.
                    if (metric > $signed(best_mag)) begin
                        best_mag   <= metric;
                        best_phase <= phase_word;
`ifdef PSK_ACQ_ABS_METRIC_EN
                        best_inv   <= acc[ACC_W-1];
`endif
                    end
                    if (phase_word == LAST_PHASE) begin
                        state <= ST_DONE;
                    end else begin
                        phase_word <= phase_word + STEP_INC;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psk_phase_acq.sv
// Scoreboard bench for psk_phase_acq: a timeline reference model pushes expected step/sweep
// results, a monitor pops them on corr_valid/done. Honours PSK_ACQ_ABS_METRIC_EN.
module tb_psk_phase_acq;

    localparam int PW    = 13;
    localparam int STEP  = 512;
    localparam int DW    = 16;
    localparam int SC    = 4;
    localparam int AW    = 16;
    localparam int NSTEP = (2 ** PW) / STEP;
    localparam int SWEEP_BUSY = NSTEP * (SC + DW + 1) + 1;
`ifdef PSK_ACQ_ABS_METRIC_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, sample_en, sample_in, i_code;
    logic [PW-1:0] phase_word, best_phase;
    logic          busy, done, corr_valid;
    logic [AW-1:0] corr_value, best_mag;
`ifdef PSK_ACQ_ABS_METRIC_EN
    logic          best_inv;
`endif

    psk_phase_acq #(
        .PHASE_W(PW), .PHASE_STEP(STEP), .DWELL(DW), .SETTLE_CYC(SC), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
        .sample_in(sample_in), .i_code(i_code), .phase_word(phase_word),
        .busy(busy), .done(done), .corr_valid(corr_valid), .corr_value(corr_value),
        .best_phase(best_phase), .best_mag(best_mag)
`ifdef PSK_ACQ_ABS_METRIC_EN
        , .best_inv(best_inv)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cv_count = 0;
    int done_count = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint all_outs();
        longint v;
        v = {phase_word, busy, done, corr_valid, corr_value, best_phase, best_mag};
`ifdef PSK_ACQ_ABS_METRIC_EN
        v = {v[60:0], best_inv};
`endif
        return v;
    endfunction

    // Carrier / NCO environment: i_code follows phase_word after three clocks.
    int          en_mode  = 0;
    int          en_ph    = 0;
    int          noise_pct = 0;
    bit          invert   = 1'b0;
    bit          tie      = 1'b0;
    logic [PW-1:0] freq     = 13'd256;
    logic [PW-1:0] true_ofs = '0;
    logic [PW-1:0] nco_t = '0, pw_d0 = '0, pw_d1 = '0, pw_d2 = '0;

    always @(posedge clk) begin
        pw_d0 <= phase_word;
        pw_d1 <= pw_d0;
        pw_d2 <= pw_d1;
        nco_t <= nco_t + freq;
    end

    always @(negedge clk) begin
        logic [PW-1:0] a, b;
        a = nco_t + pw_d2;
        b = nco_t + true_ofs;
        case (en_mode)
            0:       sample_en = 1'b1;
            1:       begin sample_en = (en_ph == 0); en_ph = (en_ph + 1) % 3; end
            default: sample_en = 1'($urandom_range(0, 1));
        endcase
        if (tie) begin
            i_code    = 1'b1;
            sample_in = 1'b1;
        end else begin
            i_code    = a[PW-1];
            sample_in = b[PW-1] ^ invert ^ (int'($urandom_range(0, 99)) < noise_pct);
        end
    end

    typedef struct {
        int corr;
        int phase;
        int bmag;
        int bphase;
        bit binv;
    } exp_t;
    exp_t q_step[$];
    exp_t q_done[$];

    task automatic model_edge(output bit ab);
        @(posedge clk);
        ab = rst;
        if (ab) begin
            q_step.delete();
            q_done.delete();
        end
    endtask

    // Reference: each step ignores SC clocks, integrates the next DW strobes, then one eval clock.
    task automatic model_sweep();
        int best_m, best_p, acc, cnt, metric;
        bit best_i, ab;
        best_m = 0; best_p = 0; best_i = 1'b0;
        for (int k = 0; k < NSTEP; k++) begin
            acc = 0; cnt = 0;
            for (int s = 0; s < SC; s++) begin
                model_edge(ab);
                if (ab) return;
            end
            while (cnt < DW) begin
                model_edge(ab);
                if (ab) return;
                if (sample_en) begin
                    acc += (sample_in == i_code) ? 1 : -1;
                    cnt++;
                end
            end
            metric = (ABS && acc < 0) ? -acc : acc;
            if (metric > best_m) begin
                best_m = metric; best_p = k * STEP; best_i = (acc < 0);
            end
            q_step.push_back('{acc, (k == NSTEP - 1) ? k * STEP : (k + 1) * STEP,
                               best_m, best_p, best_i});
            model_edge(ab);
            if (ab) return;
        end
        model_edge(ab);
        if (ab) return;
        q_done.push_back('{0, 0, best_m, best_p, best_i});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && start) model_sweep();
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (corr_valid) begin
            cv_count++;
            if (q_step.size() == 0) begin
                chk("corr_valid_spurious", corr_valid, 0);
            end else begin
                e = q_step.pop_front();
                chk("corr_value", longint'($signed(corr_value)), e.corr);
                chk("phase_word_next", phase_word, e.phase);
                chk("best_mag_run", longint'($signed(best_mag)), e.bmag);
                chk("best_phase_run", best_phase, e.bphase);
                chk("busy_in_sweep", busy, 1);
`ifdef PSK_ACQ_ABS_METRIC_EN
                chk("best_inv_run", best_inv, e.binv);
`endif
            end
        end
        if (done) begin
            done_count++;
            if (q_done.size() == 0) begin
                chk("done_spurious", done, 0);
            end else begin
                e = q_done.pop_front();
                chk("best_phase", best_phase, e.bphase);
                chk("best_mag", longint'($signed(best_mag)), e.bmag);
                chk("busy_at_done", busy, 0);
                chk("steps_pending_at_done", q_step.size(), 0);
`ifdef PSK_ACQ_ABS_METRIC_EN
                chk("best_inv", best_inv, e.binv);
`endif
            end
        end
    end

    task automatic run_sweep(input bit poke, input bit chk_lat);
        int c0, d0, bcyc;
        c0 = cv_count; d0 = done_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", busy, 1);
        bcyc = 1;
        for (int i = 0; i < 5000 && done_count == d0; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            start = (poke && i == 100);
        end
        start = 1'b0;
        chk("done_seen", done_count - d0, 1);
        repeat (10) @(negedge clk);
        chk("done_once", done_count - d0, 1);
        chk("corr_valid_count", cv_count - c0, NSTEP);
        if (chk_lat) chk("busy_cycles", bcyc, SWEEP_BUSY);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 9) chk("idle_outputs_zero", all_outs(), 0);
        end

        // Clean carrier at 4096: that step alone reaches +DW.
        en_mode = 0; freq = 13'd256; true_ofs = 13'd4096; noise_pct = 0;
        run_sweep(1'b0, 1'b1);
        chk("match_best_phase", best_phase, 4096);
        chk("match_best_mag", best_mag, DW);

        // Inverted carrier at 0.
        invert = 1'b1; true_ofs = '0;
        run_sweep(1'b0, 1'b1);
`ifdef PSK_ACQ_ABS_METRIC_EN
        chk("inv_best_phase", best_phase, 0);
        chk("inv_best_inv", best_inv, 1);
`else
        chk("inv_best_phase", best_phase, 4096);
`endif
        chk("inv_best_mag", best_mag, DW);
        invert = 1'b0;

        // Sparse strobes with noise.
        en_mode = 1; freq = 13'd333; true_ofs = 13'($urandom_range(0, 8191)); noise_pct = 10;
        run_sweep(1'b0, 1'b0);

        // Every step ties at +DW: earliest phase wins.
        en_mode = 0; tie = 1'b1;
        run_sweep(1'b0, 1'b1);
        chk("tie_best_phase", best_phase, 0);
        chk("tie_best_mag", best_mag, DW);
        tie = 1'b0;

        // Random strobes/noise, with a start pulse while busy.
        en_mode = 2; freq = 13'($urandom_range(100, 900));
        true_ofs = 13'($urandom_range(0, 8191)); noise_pct = 20;
        run_sweep(1'b1, 1'b0);

        // Abort in DWELL of step 2, start coincident with rst.
        en_mode = 0; freq = 13'd256; noise_pct = 0; true_ofs = 13'd1536;
        c0 = cv_count; d0 = done_count;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000 && (cv_count - c0) < 2; i++) @(negedge clk);
        chk("abort_reached_step2", cv_count - c0, 2);
        repeat (8) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("abort_outputs_zero", all_outs(), 0);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_count - d0, 0);
        chk("abort_no_extra_corr", cv_count - c0, 2);
        chk("abort_start_ignored_busy", busy, 0);
        run_sweep(1'b0, 1'b1);
        chk("restart_best_phase", best_phase, 1536);
        chk("restart_best_mag", best_mag, DW);

        chk("queues_drained", q_step.size() + q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
